// File: rtl/jk_bank_controller_if.sv
// Command channel for jk_bank_controller.
// It carries one command at a time using a valid/ready handshake.
//   cmd_valid  : a command is present (driven by master)
//   cmd_ready  : controller can accept a command (driven by slave)
//   cmd_op     : 3-bit operation code
//   cmd_data   : load value or toggle mask
//   cmd_count  : step count for INC/DEC/TOGGLE (0 is treated as 1)
interface jk_bank_controller_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/jk_bank_controller.sv
// jk_bank_controller: sequences register-level operations onto an external
// bank of WIDTH JK flip-flops.
//
// Each step does the following:
//   1. It drives j/k for one cycle (APPLY).
//   2. It reads the bank back in the next cycle (CHECK).
//   3. It compares q against the predicted next value.
//
// Ports:
//   clk, rst  : rising-edge clock shared with the bank; sync active-high reset
//   cmd       : command handshake (slave side of jk_bank_controller_if)
//   j, k      : registered J/K drive to the bank
//   q         : bank state readback
//   busy      : command in progress
//   done      : one-cycle pulse when a command completes
//   err       : sticky mismatch / illegal-op flag for the current or last command
module jk_bank_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_bank_controller_if.slave  cmd,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] nxt;
  } step_t;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_CLEAR  = 3'b010;
  localparam logic [2:0] OP_SET    = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_INC    = 3'b101;
  localparam logic [2:0] OP_DEC    = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             err_q, err_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  step_t            pred;

  // J/K drive and the predicted next q for one step, computed from the
  // current readback.
  // For INC and DEC, a bit toggles when all lower bits are 1 (INC) or all
  // lower bits are 0 (DEC). This is a ripple-carry or ripple-borrow chain.
  function automatic step_t predict(input logic [2:0]       op,
                                    input logic [WIDTH-1:0] data,
                                    input logic [WIDTH-1:0] cur);
    step_t            s;
    logic [WIDTH-1:0] chain;
    logic             run;
    s     = '0;
    chain = '0;
    run   = 1'b1;
    case (op)
      OP_HOLD:   s.nxt = cur;
      OP_LOAD:   begin s.j = data; s.k = ~data; s.nxt = data; end
      OP_CLEAR:  begin s.k = '1; s.nxt = '0; end
      OP_SET:    begin s.j = '1; s.nxt = '1; end
      OP_TOGGLE: begin s.j = data; s.k = data; s.nxt = cur ^ data; end
      OP_INC: begin
        for (int i = 0; i < WIDTH; i++) begin
          chain[i] = run;
          run      = run & cur[i];
        end
        s.j = chain; s.k = chain; s.nxt = cur + WIDTH'(1);
      end
      OP_DEC: begin
        for (int i = 0; i < WIDTH; i++) begin
          chain[i] = run;
          run      = run & ~cur[i];
        end
        s.j = chain; s.k = chain; s.nxt = cur - WIDTH'(1);
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  assign accept        = (state_q == S_IDLE) && cmd.cmd_valid;
  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign j             = j_q;
  assign k             = k_q;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    exp_d   = exp_q;
    steps_d = steps_q;
    err_d   = err_q;
    pred    = '0;
    case (state_q)
      S_IDLE: begin
        j_d = '0;
        k_d = '0;
        if (accept) begin
          err_d = 1'b0;
          if (cmd.cmd_op == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pred    = predict(cmd.cmd_op, cmd.cmd_data, q);
            j_d     = pred.j;
            k_d     = pred.k;
            exp_d   = pred.nxt;
            steps_d = CNT_W'(1);
            if ((cmd.cmd_op == OP_TOGGLE || cmd.cmd_op == OP_INC ||
                 cmd.cmd_op == OP_DEC) && cmd.cmd_count != '0)
              steps_d = cmd.cmd_count;
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        j_d     = '0;
        k_d     = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (q != exp_q) err_d = 1'b1;
        steps_d = steps_q - CNT_W'(1);
        // The next prediction uses the q value read now, not exp_q.
        // This way, a single faulty step does not cascade into later steps.
        if (steps_q > CNT_W'(1)) begin
          pred    = predict(op_q, data_q, q);
          j_d     = pred.j;
          k_d     = pred.k;
          exp_d   = pred.nxt;
          state_d = S_APPLY;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      exp_q   <= '0;
      steps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      steps_q <= steps_d;
      err_q   <= err_d;
    end
  end

  // Command fields are only consulted while busy, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd.cmd_op;
      data_q <= cmd.cmd_data;
    end
  end

endmodule

// File: doc/jk_bank_controller.md
Name: jk_bank_controller

Overview:
- Command sequencer for an external bank of WIDTH JK flip-flops, one JK cell per bit, all on the same clk.
- Accepts one command at a time over a valid/ready handshake. Drives the bank's j/k inputs one step at a time and reads back q.
- After every step it checks the bank's new q against a predicted value and flags any mismatch.
- Sits between test or control logic and the flip-flop bank, so callers issue register-level ops (load, count, toggle) and never hand-drive J/K.

Parameters:
- WIDTH, 4, number of JK cells in the controlled bank (2..16).
- CNT_W, 8, width of the step-count field.

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (high only in IDLE)
- cmd_op  input  3  operation code
- cmd_data  input  WIDTH  load value or toggle mask
- cmd_count  input  CNT_W  number of steps for INC/DEC/TOGGLE
- j  output  WIDTH  J inputs to bank, registered
- k  output  WIDTH  K inputs to bank, registered
- q  input  WIDTH  bank state readback
- busy  output  1  command in progress (state != IDLE)
- done  output  1  one-cycle pulse at command completion
- err  output  1  sticky mismatch or illegal-op flag for the current/last command

Behaviour:
- Reset (sync, rst high at posedge): state=IDLE; j=0, k=0 (bank holds); busy=0, done=0, err=0; step counter=0, expected=0.
  - rst does not reset the bank itself. q is unknown until a CLEAR/LOAD completes.
  - rst mid-command aborts immediately; no done pulse.
- States: IDLE -> APPLY -> CHECK -> (APPLY | DONE) -> IDLE.
- IDLE: cmd_ready=1, j=k=0. Accept on posedge with cmd_valid&cmd_ready.
  - Latch op, data, steps, where steps = (cmd_count==0 ? 1 : cmd_count) for INC/DEC/TOGGLE and steps=1 for all other ops.
  - Clear err.
  - Register j/k and expected from the current q.
  - Go to APPLY.
- APPLY (1 cycle): j/k stable; bank samples them at the end of this cycle. Next: CHECK with j=k=0.
- CHECK (1 cycle):
  - Compare q with expected; set err on mismatch (err stays set to end of command).
  - Decrement steps.
  - If steps remain: compute next j/k/expected from the current q and go to APPLY.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=1. Next: IDLE.
- cmd_valid while busy is ignored; no queuing.
- Op encoding (J/K per bit i, expected = next q):
  - 000 HOLD: j=0, k=0; expected=q.
  - 001 LOAD: j=data, k=~data; expected=data.
  - 010 CLEAR: j=0, k=all-1; expected=0.
  - 011 SET: j=all-1, k=0; expected=all-1.
  - 100 TOGGLE: j=k=data; expected=q^data; repeated per step.
  - 101 INC: j[i]=k[i]=&q[i-1:0] (bit 0 always 1); expected=q+1 mod 2^WIDTH.
  - 110 DEC: j[i]=k[i]=&~q[i-1:0]; expected=q-1 mod 2^WIDTH.
  - 111 reserved: go straight IDLE->DONE without driving j/k; err=1.
- Wrap-around: INC from all-1 gives 0, DEC from 0 gives all-1; no saturation.
- Latency: N steps take 2N cycles after the accept edge. done is high in cycle 2N+1, and cmd_ready returns in cycle 2N+2. Reserved op: done in cycle 1.
- Predictions always use the q read in the current IDLE/CHECK cycle, never the previous expected. A faulty bit therefore flags err once per bad step but does not cascade.

Test Plan:
- (WIDTH=4) rst, then CLEAR: j=0000, k=1111 in APPLY; q=0 in CHECK; done in cycle 3; err=0.
- LOAD data=0xA from q=0: j=1010, k=0101 in APPLY; q=0xA; done in cycle 3; err=0.
- INC count=3 from q=0xE: q reads F,0,1 in successive CHECK cycles; done in cycle 7; err=0. DEC count=1 from q=0 gives q=F.
- TOGGLE data=0x5 count=2 from q=0x3: q=0x6 then 0x3; done in cycle 5.
- Fault injection: bench forces q[2] stuck at 0, then INC from 0x3: expected 0x4, read 0x0 -> err=1 through done; next accepted command clears err.
- rst asserted during APPLY of INC count=5: next cycle state IDLE, j=k=0, busy=0, no done pulse. Reserved op 111: done in cycle 1 with err=1, j/k stay 0. cmd_valid held during busy is not accepted (cmd_ready=0).
